// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_pkg                                                        |
// | Purpose  : Shared types and frame-length helpers for the parametrised      |
// |            UART transmitter (parity modes, FSM states, frame sizing).      |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial parametrised release                              |
// +----------------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_PAR   = 3'd4,
    ST_STOP  = 3'd5
  } tx_state_e;

  // Wide enough to index up to 9 data bits or 2 stop bits.
  localparam int BIT_CNT_W = 4;

  // Longest legal frame: start + 9 data + parity + 2 stop.
  localparam int MAX_FRAME_BITS = 13;

  // Number of bit periods in one frame.
  function automatic int frame_bits(input int data_w, input int parity, input int stop_bits);
    return 1 + data_w + ((parity != 0) ? 1 : 0) + stop_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_baud_gen                                                   |
// | Purpose  : Bit-period timer. Counts 0..div and wraps; tick marks the last  |
// |            cycle of every bit period.                                      |
// | Ports    : CLK   - system clock                                            |
// |            rst   - synchronous reset, active-high                          |
// |            en    - count enable (counter holds when low)                   |
// |            clear - restart the period at 0 (start-bit entry)               |
// |            div   - bit period minus one, in CLK cycles                     |
// |            tick  - high on the last cycle of a bit period                  |
// | Revision : 1.0 - initial parametrised release                              |
// +----------------------------------------------------------------------------+
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      if (r_cnt == div) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign tick = en && (r_cnt == div);

endmodule
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_param                                                   |
// | Purpose  : Parametrised UART transmitter: configurable data width, parity, |
// |            stop bits, runtime baud divisor, ready/done handshake and       |
// |            optional RTS/CTS flow control.                                  |
// | Ports    : CLK        - system clock                                       |
// |            rst        - synchronous reset, active-high (aborts a frame)    |
// |            en         - global enable; low freezes all state               |
// |            baud_div   - bit period minus one, latched at accept            |
// |            tx_start   - send request, taken when ready is high             |
// |            data       - frame payload, latched at accept                   |
// |            CTS        - clear-to-send from far end                         |
// |            ready      - idle and enabled                                   |
// |            RTS        - request-to-send                                    |
// |            serial_out - TX line, idle high                                 |
// |            done       - pulse on the last cycle of the last stop bit       |
// | Revision : 1.0 - initial parametrised release                              |
// +----------------------------------------------------------------------------+
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_W     = 16,
  parameter int CTS_EN    = 1
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              en,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] data,
  input  logic              CTS,
  output logic              ready,
  output logic              RTS,
  output logic              serial_out,
  output logic              done
);

  generate
    if ((DATA_W < 5) || (DATA_W > 9) || (PARITY < 0) || (PARITY > 2) ||
        (STOP_BITS < 1) || (STOP_BITS > 2) ||
        (frame_bits(DATA_W, PARITY, STOP_BITS) > MAX_FRAME_BITS)) begin : g_param_check
      $error("uart_tx_param: illegal DATA_W / PARITY / STOP_BITS");
    end
  endgenerate

  localparam logic [BIT_CNT_W-1:0] c_LAST_DATA = BIT_CNT_W'(DATA_W - 1);
  localparam logic [BIT_CNT_W-1:0] c_LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  tx_state_e             r_state;
  logic [DATA_W-1:0]     r_shift;
  logic                  r_par;
  logic [DIV_W-1:0]      r_div;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic                  r_rts;
  logic                  r_line;

  logic                  w_tick;
  logic                  w_busy;
  logic                  w_go_start;
  logic                  w_par;

  // Parity is taken from the payload as it is latched, so later data changes
  // cannot corrupt it.
  assign w_par = (PARITY == int'(PAR_ODD)) ? ~(^data) : (^data);

  assign w_busy = (r_state == ST_START) || (r_state == ST_DATA) ||
                  (r_state == ST_PAR)   || (r_state == ST_STOP);

  // Start-bit entry: straight from IDLE without flow control, else from REQ
  // once CTS is seen. The bit timer restarts here.
  assign w_go_start = en && (((r_state == ST_IDLE) && tx_start && (CTS_EN == 0)) ||
                             ((r_state == ST_REQ) && CTS));

  uart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud (
    .CLK   (CLK),
    .rst   (rst),
    .en    (en && w_busy),
    .clear (w_go_start),
    .div   (r_div),
    .tick  (w_tick)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_div     <= '0;
      r_bit_cnt <= '0;
      r_rts     <= 1'b0;
      r_line    <= 1'b1;
    end else if (en) begin
      case (r_state)
        ST_IDLE: begin
          if (tx_start) begin
            r_shift   <= data;
            r_par     <= w_par;
            r_div     <= baud_div;
            r_bit_cnt <= '0;
            if (CTS_EN != 0) begin
              r_state <= ST_REQ;
              r_rts   <= 1'b1;
            end else begin
              r_state <= ST_START;
              r_line  <= 1'b0;
            end
          end
        end
        ST_REQ: begin
          if (CTS) begin
            r_state <= ST_START;
            r_line  <= 1'b0;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_state   <= ST_DATA;
            r_line    <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_bit_cnt == c_LAST_DATA) begin
              r_bit_cnt <= '0;
              if (PARITY != 0) begin
                r_state <= ST_PAR;
                r_line  <= r_par;
              end else begin
                r_state <= ST_STOP;
                r_line  <= 1'b1;
              end
            end else begin
              r_line    <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        ST_PAR: begin
          if (w_tick) begin
            r_state   <= ST_STOP;
            r_line    <= 1'b1;
            r_bit_cnt <= '0;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (r_bit_cnt == c_LAST_STOP) begin
              r_state <= ST_IDLE;
              r_rts   <= 1'b0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_rts   <= 1'b0;
          r_line  <= 1'b1;
        end
      endcase
    end
  end

  assign ready      = (r_state == ST_IDLE) && en;
  assign RTS        = r_rts;
  assign serial_out = r_line;
  // Decoded from registered state; w_tick already carries en, so a frozen
  // block never pulses done.
  assign done       = w_tick && (r_state == ST_STOP) && (r_bit_cnt == c_LAST_STOP);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_tx_param                                                |
// | Purpose  : Directed self-checking bench for uart_tx_param, four configs.   |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_uart_tx_param;

  logic        clk;
  logic        rst;
  logic [3:0]  en;
  logic [3:0]  tx_start;
  logic [3:0]  cts;
  logic [3:0]  ready;
  logic [3:0]  rts;
  logic [3:0]  so;
  logic [3:0]  done;
  logic [8:0]  data [4];
  logic [15:0] div  [4];

  int total = 0;
  int bad   = 0;

  // 0: 8 bits, even, 1 stop, no flow control
  uart_tx_param #(.DATA_W(8), .PARITY(2), .STOP_BITS(1), .DIV_W(16), .CTS_EN(0)) u0 (
    .CLK(clk), .rst(rst), .en(en[0]), .baud_div(div[0]), .tx_start(tx_start[0]),
    .data(data[0][7:0]), .CTS(cts[0]), .ready(ready[0]), .RTS(rts[0]),
    .serial_out(so[0]), .done(done[0]));

  // 1: 8 bits, odd, 2 stop, no flow control
  uart_tx_param #(.DATA_W(8), .PARITY(1), .STOP_BITS(2), .DIV_W(16), .CTS_EN(0)) u1 (
    .CLK(clk), .rst(rst), .en(en[1]), .baud_div(div[1]), .tx_start(tx_start[1]),
    .data(data[1][7:0]), .CTS(cts[1]), .ready(ready[1]), .RTS(rts[1]),
    .serial_out(so[1]), .done(done[1]));

  // 2: 8 bits, no parity, 1 stop, RTS/CTS
  uart_tx_param #(.DATA_W(8), .PARITY(0), .STOP_BITS(1), .DIV_W(16), .CTS_EN(1)) u2 (
    .CLK(clk), .rst(rst), .en(en[2]), .baud_div(div[2]), .tx_start(tx_start[2]),
    .data(data[2][7:0]), .CTS(cts[2]), .ready(ready[2]), .RTS(rts[2]),
    .serial_out(so[2]), .done(done[2]));

  // 3: 5 bits, no parity, 1 stop, no flow control
  uart_tx_param #(.DATA_W(5), .PARITY(0), .STOP_BITS(1), .DIV_W(16), .CTS_EN(0)) u3 (
    .CLK(clk), .rst(rst), .en(en[3]), .baud_div(div[3]), .tx_start(tx_start[3]),
    .data(data[3][4:0]), .CTS(cts[3]), .ready(ready[3]), .RTS(rts[3]),
    .serial_out(so[3]), .done(done[3]));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Each bit of the LSB-first list held for rep cycles.
  function automatic logic [127:0] expand(input logic [15:0] bits, input int nbits, input int rep);
    logic [127:0] v = '0;
    for (int j = 0; j < nbits * rep; j++) v[j] = bits[j / rep];
    return v;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic kick(input int k, input logic [8:0] d, input logic [15:0] dv);
    data[k]     = d;
    div[k]      = dv;
    tx_start[k] = 1'b1;
    @(negedge clk);
    tx_start[k] = 1'b0;
    div[k]      = ~dv;
    data[k]     = ~d;
  endtask

  // Samples n consecutive negedges, the first one being the current one.
  task automatic capture(input int k, input int n, output logic [127:0] line,
                         output logic [127:0] rts_line, output int d_cnt,
                         output int d_first, output int d_last);
    line = '0; rts_line = '0; d_cnt = 0; d_first = 0; d_last = 0;
    for (int i = 0; i < n; i++) begin
      if (i != 0) @(negedge clk);
      line[i]     = so[k];
      rts_line[i] = rts[k];
      if (done[k]) begin
        d_cnt++;
        if (d_first == 0) d_first = i + 1;
        d_last = i + 1;
      end
    end
  endtask

  initial begin
    logic [127:0] line, rline, base, e;
    int dc, df, dl, dsum;

    clk = 1'b0; rst = 1'b1; en = 4'hF; tx_start = 4'h0; cts = 4'h0;
    for (int k = 0; k < 4; k++) begin data[k] = '0; div[k] = '0; end
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_line",  128'(so),    128'hF);
    check("rst_rts",   128'(rts),   128'h0);
    check("rst_done",  128'(done),  128'h0);
    check("rst_ready", 128'(ready), 128'hF);
    rst = 1'b0;
    @(negedge clk);

    // 1: 0xA5 even parity, div=3
    kick(0, 9'h0A5, 16'd3);
    capture(0, 44, line, rline, dc, df, dl);
    check("t1_line", line, expand(16'h054A, 11, 4));
    check("t1_done_pos", 128'(df), 128'd44);
    check("t1_done_cnt", 128'(dc), 128'd1);
    @(negedge clk);
    check("t1_ready_after", 128'({ready[0], so[0]}), 128'b11);

    // 2: 0x00 odd parity, 2 stop, div=0
    kick(1, 9'h000, 16'd0);
    capture(1, 12, line, rline, dc, df, dl);
    check("t2_line", line, 128'hE00);
    check("t2_done_pos", 128'(df), 128'd12);
    check("t2_done_cnt", 128'(dc), 128'd1);
    @(negedge clk);
    check("t2_ready_after", 128'(ready[1]), 128'd1);

    // 3: CTS held low 20 cycles, dropped again mid-data
    cts[2] = 1'b0;
    kick(2, 9'h03C, 16'd1);
    check("t3_ready_req", 128'(ready[2]), 128'd0);
    capture(2, 20, line, rline, dc, df, dl);
    check("t3_wait_line", line, 128'hFFFFF);
    check("t3_wait_rts", rline, 128'hFFFFF);
    cts[2] = 1'b1;
    @(negedge clk);
    fork
      capture(2, 20, line, rline, dc, df, dl);
      begin
        repeat (8) @(negedge clk);
        cts[2] = 1'b0;
      end
    join
    check("t3_line", line, expand(16'h0278, 10, 2));
    check("t3_rts", rline, 128'hFFFFF);
    check("t3_done_pos", 128'(df), 128'd20);
    @(negedge clk);
    check("t3_after", 128'({rts[2], ready[2]}), 128'b01);

    // 4: reset during data bit 3 abandons the frame
    kick(0, 9'h0A5, 16'd3);
    dsum = 0;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (done[0]) dsum++;
    end
    check("t4_mid_bit3", 128'(so[0]), 128'd0);
    rst = 1'b1;
    @(negedge clk);
    check("t4_after_rst", 128'({so[0], rts[0], ready[0], done[0]}), 128'b1010);
    tx_start[0] = 1'b1;
    data[0] = 9'h000;
    @(negedge clk);
    rst = 1'b0;
    tx_start[0] = 1'b0;
    check("t4_rst_wins", 128'({so[0], ready[0]}), 128'b11);
    capture(0, 10, line, rline, dc, df, dl);
    dsum = dsum + dc;
    check("t4_idle_line", line, 128'h3FF);
    check("t4_no_done", 128'(dsum), 128'd0);
    @(negedge clk);
    kick(0, 9'h0A5, 16'd3);
    capture(0, 44, line, rline, dc, df, dl);
    check("t4_clean_frame", line, expand(16'h054A, 11, 4));
    check("t4_clean_done", 128'(df), 128'd44);
    @(negedge clk);

    // 5: en low 10 cycles inside the parity bit
    kick(0, 9'h0A5, 16'd3);
    fork
      capture(0, 54, line, rline, dc, df, dl);
      begin
        repeat (37) @(negedge clk);
        en[0] = 1'b0;
        tx_start[0] = 1'b1;
        data[0] = 9'h1FF;
        @(negedge clk);
        tx_start[0] = 1'b0;
        repeat (9) @(negedge clk);
        en[0] = 1'b1;
      end
    join
    base = expand(16'h054A, 11, 4);
    e = '0;
    for (int j = 0; j < 54; j++) e[j] = base[(j <= 37) ? j : ((j <= 47) ? 37 : j - 10)];
    check("t5_line", line, e);
    check("t5_done_pos", 128'(df), 128'd54);
    check("t5_done_cnt", 128'(dc), 128'd1);
    @(negedge clk);
    en[0] = 1'b0;
    tx_start[0] = 1'b1;
    @(negedge clk);
    check("t5_ready_dis", 128'(ready[0]), 128'd0);
    tx_start[0] = 1'b0;
    en[0] = 1'b1;
    capture(0, 6, line, rline, dc, df, dl);
    check("t5_ignored", line, 128'h3F);

    // 6: 5-bit back-to-back frames with tx_start held
    @(negedge clk);
    data[3] = 9'h015;
    div[3] = 16'd1;
    tx_start[3] = 1'b1;
    @(negedge clk);
    data[3] = 9'h00A;
    capture(3, 29, line, rline, dc, df, dl);
    tx_start[3] = 1'b0;
    e = expand(16'h006A, 7, 2) | (128'd1 << 14) | (expand(16'h0054, 7, 2) << 15);
    check("t6_line", line, e);
    check("t6_done_cnt", 128'(dc), 128'd2);
    check("t6_done_first", 128'(df), 128'd14);
    check("t6_done_last", 128'(dl), 128'd29);
    repeat (2) @(negedge clk);
    check("t6_idle", 128'({so[3], ready[3]}), 128'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
